// File: rtl/uart_alu_resp_tx.sv
// rtl/uart_alu_resp_tx.sv - UART ALU response serializer (6-byte 8N1 packet)
//
// Accepts one 32-bit ALU result through a valid/ready handshake and sends it
// as the packet: HEADER_BYTE, result[7:0], result[15:8], result[23:16],
// result[31:24], checksum (XOR of the four result bytes). Each byte is sent
// as one 8N1 frame, LSB first, with no gap between the bytes of a packet.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-high reset
//   result_i  ALU result, sampled only on the handshake
//   valid_i   result_i is valid
//   ready_o   can accept a result (IDLE only)
//   tx_o      serial output, idles high, driven from a flop
//   busy_o    packet in flight (~ready_o)
module uart_alu_resp_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] result_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_alu_resp_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         csum_q, csum_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic               tx_q, tx_d;
  logic [7:0]         cur_byte;
  logic               baud_done;

  // byte_idx_q only changes on entry to START, so it is stable through the
  // whole DATA phase of the byte it selects.
  always_comb begin
    cur_byte = HEADER_BYTE;
    case (byte_idx_q)
      3'd1:    cur_byte = data_q[7:0];
      3'd2:    cur_byte = data_q[15:8];
      3'd3:    cur_byte = data_q[23:16];
      3'd4:    cur_byte = data_q[31:24];
      3'd5:    cur_byte = csum_q;
      default: cur_byte = HEADER_BYTE;
    endcase
  end

  assign baud_done = (baud_q == BAUD_LAST);

  // tx_d is the line level for the state being entered, so the registered
  // tx_q changes in the same cycle as state_q and never glitches.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    csum_d     = csum_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q + BAUD_W'(1);
    tx_d       = tx_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (valid_i) begin
          data_d     = result_i;
          csum_d     = result_i[7:0] ^ result_i[15:8] ^ result_i[23:16] ^ result_i[31:24];
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_idx_q];
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (byte_idx_q < 3'd5) begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = START;
            tx_d       = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      data_q     <= '0;
      csum_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      csum_q     <= csum_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = ~ready_o;
  assign tx_o    = tx_q;

endmodule

// File: tb/tb_uart_alu_resp_tx.sv
// tb/tb_uart_alu_resp_tx.sv - self-checking bench for uart_alu_resp_tx
module tb_uart_alu_resp_tx;

  localparam int C = 16;
  localparam int PKT = 60 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result = '0;
  logic        valid = 1'b0;
  logic        ready, tx, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;

  uart_alu_resp_tx #(.CLKS_PER_BIT(C), .HEADER_BYTE(8'hA5)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .result_i(result),
    .valid_i (valid),
    .ready_o (ready),
    .tx_o    (tx),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string           name;
    logic [31:0]     res;
    logic [5:0][7:0] exp;
    int              mode;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for ready at a negedge, present the result, let the
  // handshake edge pass. Returns just after that rising edge.
  task automatic send(input logic [31:0] res, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready_wait"}, ready, 1'b1);
    chk({name, " tx_idle_before"}, tx, 1'b1);
    result = res;
    valid  = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the handshake edge T. Sample cycle k at negedge = T+k.
  // mode 0: plain; 1: disturb result/valid during byte 2; 2: keep valid high
  // and present nxt for a back-to-back packet.
  task automatic watch(input string name, input logic [5:0][7:0] exp,
                       input int mode, input logic [31:0] nxt);
    logic [59:0] got;
    int bad_ready;
    got = '0;
    bad_ready = 0;
    for (int k = 1; k <= PKT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_cyc = cyc;
        chk({name, " tx_fall_T+1"}, tx, 1'b0);
        if (mode == 2) result = nxt;
        else valid = 1'b0;
      end
      if (mode == 1 && k == 22 * C) begin
        result = 32'hDEADBEEF;
        valid  = 1'b1;
      end
      if (mode == 1 && k == 23 * C) valid = 1'b0;
      if (k >= C / 2 && ((k - C / 2) % C) == 0 && (k - C / 2) / C < 60)
        got[(k - C / 2) / C] = tx;
      if (k <= PKT && (ready || !busy)) bad_ready++;
      if (k == PKT + 1) begin
        chk({name, " ready_at_T+60C+1"}, ready, 1'b1);
        chk({name, " busy_at_T+60C+1"}, busy, 1'b0);
        chk({name, " tx_idle_after"}, tx, 1'b1);
      end
    end
    chk({name, " ready_low_in_packet"}, bad_ready, 0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s frame%0d", name, i), got[i*10 +: 10], {1'b1, exp[i], 1'b0});
  endtask

  initial begin
    int tx_low;
    int b2b_first;

    vecs[0] = '{"v12345678", 32'h12345678,
                {8'h08, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA5}, 0};
    vecs[1] = '{"vzero", 32'h00000000,
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, 0};
    vecs[2] = '{"vones", 32'hFFFFFFFF,
                {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5}, 0};
    vecs[3] = '{"vdisturb", 32'hCAFEF00D,
                {8'hC9, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hA5}, 1};

    // Reset with valid held high: no start bit, idle outputs.
    valid  = 1'b1;
    result = 32'h12345678;
    tx_low = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!tx) tx_low++;
    end
    chk("rst tx_stays_high", tx_low, 0);
    chk("rst ready", ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst tx", tx, 1'b1);
    chk("post_rst ready", ready, 1'b1);

    for (int v = 0; v < 4; v++) begin
      send(vecs[v].res, vecs[v].name);
      watch(vecs[v].name, vecs[v].exp, vecs[v].mode, 32'h0);
    end

    // Back-to-back with valid held high.
    send(32'h00000001, "b2b_a");
    watch("b2b_a", {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA5}, 2, 32'h80000000);
    b2b_first = start_cyc;
    @(posedge clk);
    watch("b2b_b", {8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'hA5}, 0, 32'h0);
    chk("b2b period", start_cyc - b2b_first, PKT + 1);

    // Reset during a zero data bit of byte 3 (result[23:16] = 00).
    send(32'hCC00AA55, "rstmid");
    for (int k = 1; k <= 33 * C + C / 2; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
    end
    chk("rstmid tx_low_before", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid tx_async_high", tx, 1'b1);
    chk("rstmid ready_async", ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid ready_after", ready, 1'b1);
    chk("rstmid tx_after", tx, 1'b1);
    send(32'hA1B2C3D4, "after_rst");
    watch("after_rst", {8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA5}, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_alu_resp_tx.md
# uart_alu_resp_tx

Response-path serializer for the UART ALU. It accepts one 32-bit ALU result through a valid/ready handshake and frames it as a 6-byte response packet. It transmits the packet as 8N1 UART serial data on a single line. It sits between the ALU result stage and the top-level serial TX pin, and is the transmit-side counterpart of the command receiver/decoder.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit period; legal range is ≥ 2 (elaboration-time assertion).
- HEADER_BYTE, default 8'hA5: first byte of every response packet.

Ports:
- clk_i  input  1  the single clock; all logic is rising-edge.
- rst_i  input  1  reset, asynchronous and active-high.
- result_i  input  32  ALU result; sampled only on handshake.
- valid_i  input  1  result_i is valid.
- ready_o  output  1  block can accept a result; high only in IDLE.
- tx_o  output  1  UART serial output; idle level is 1.
- busy_o  output  1  a packet is in flight; equals ~ready_o.

## Operation
- Packet, in order: HEADER_BYTE, result[7:0], result[15:8], result[23:16], result[31:24], checksum.
- checksum = XOR of the four result bytes.
- Each byte is one frame: start bit (0), 8 data bits LSB first, stop bit (1). That is 10 bit periods per byte and 60 per packet.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: tx_o=1, ready_o=1. On valid_i && ready_o:
  - latch result_i into a 32-bit register;
  - compute and latch the checksum;
  - clear the byte index to 0;
  - go to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx_o = current_byte[bit index] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
- STOP: tx_o=1 for CLKS_PER_BIT cycles. Then:
  - if byte index < 5: increment the index and go to START, with no gap between bytes;
  - else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets on every state or bit advance, and is sized $clog2(CLKS_PER_BIT).
- result_i and valid_i are ignored outside IDLE. Changing result_i mid-packet has no effect on the output.
- tx_o is driven from a flop, so it is glitch-free.

## Timing
- Reset values: tx_o=1, ready_o=1, busy_o=0, state=IDLE, all counters 0.
- Handshake accepted at rising edge T:
  - tx_o falls at T+1 (first start-bit cycle);
  - bit n of the packet (n = 0..59) occupies cycles T+1+n·C through T+(n+1)·C, where C = CLKS_PER_BIT;
  - the last stop bit ends at cycle T+60·C;
  - ready_o=1 at cycle T+60·C+1.
- Back-to-back: with valid_i held high, the next result is accepted in the first IDLE cycle. This gives exactly one idle-high cycle between packets, so the packet-to-packet period is 60·C+1 cycles.
- valid_i without ready_o: no effect. The producer must hold valid_i and the data until ready_o.
- Reset mid-packet: tx_o returns to 1 immediately (asynchronously), the in-flight packet is dropped, and ready_o=1 the first cycle after rst_i deasserts. There is no partial retransmit.
- valid_i high during reset: not accepted. Acceptance is possible no earlier than the first clock edge after deassertion.

## Test plan
- Reset check: assert rst_i mid-idle -> tx_o=1, ready_o=1, busy_o=0. Hold valid_i=1 during reset -> no start bit.
- Single packet, C=16, result_i=32'h12345678 -> serial bytes A5 78 56 34 12 08. Each bit is 16 cycles, tx_o falls at T+1, ready_o returns at T+961. The A5 data bits in order are 1,0,1,0,0,1,0,1.
- Zero/all-ones: result_i=32'h00000000 -> bytes A5 00 00 00 00 00. result_i=32'hFFFFFFFF -> bytes A5 FF FF FF FF 00. Stop bits are always 1.
- Back-to-back: valid_i held high with 32'h00000001 then 32'h80000000 -> second start bit begins exactly 961 cycles after the first. Checksums are 01 and 80.
- Mid-packet disturbance: change result_i and pulse valid_i during byte 2 -> transmitted bytes unchanged and ready_o stays low.
- Reset mid-packet: assert rst_i during DATA of byte 3 -> tx_o=1 within the same cycle. The next packet after release is sent intact from its header.
